wb2axi4l_bridge: RTL
====================

WB2AXI4L_BRIDGE -- requirements
Module: wb2axi4l_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of the Wishbone and AXI4-Lite address buses; data width is fixed at 32, strobe/select width at 4.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 wb_rst_i  in  1  synchronous active-high reset.
REQ-005 wb_adr_i  in  ADDR_WIDTH  Wishbone byte address.
REQ-006 wb_dat_i  in  32  Wishbone write data.
REQ-007 wb_sel_i  in  4  Wishbone byte selects.
REQ-008 wb_we_i  in  1  1 = write, 0 = read.
REQ-009 wb_cyc_i  in  1  bus cycle active.
REQ-010 wb_stb_i  in  1  transfer strobe.
REQ-011 wb_dat_o  out  32  read data, registered.
REQ-012 wb_ack_o  out  1  normal termination, one-cycle pulse.
REQ-013 wb_err_o  out  1  error termination, one-cycle pulse.
REQ-014 m_axi_awaddr  out  ADDR_WIDTH; m_axi_awvalid  out  1; m_axi_awready  in  1: AW channel.
REQ-015 m_axi_wdata  out  32; m_axi_wstrb  out  4; m_axi_wvalid  out  1; m_axi_wready  in  1: W channel.
REQ-016 m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1: B channel.
REQ-017 m_axi_araddr  out  ADDR_WIDTH; m_axi_arvalid  out  1; m_axi_arready  in  1: AR channel.
REQ-018 m_axi_rdata  in  32; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1: R channel.

Function
REQ-019 FSM states: IDLE, WADDR (AW and/or W outstanding), WRESP, RADDR, RRESP, DONE; all outputs registered.
REQ-020 IDLE: on wb_cyc_i & wb_stb_i, capture adr/dat/sel; go to WADDR if wb_we_i else RADDR; awvalid+wvalid or arvalid high from the next cycle.
REQ-021 Each valid SHALL stay high with stable address/data/strobe until its own handshake (valid & ready at a clock edge), then drop the next cycle; valid never depends on ready.
REQ-022 WADDR: AW and W handshakes tracked independently, in any order or the same cycle; go to WRESP only after both have completed.
REQ-023 bready high only in WRESP, rready only in RRESP; awaddr=araddr=captured wb_adr_i unmodified; wstrb=captured wb_sel_i; wb_sel_i ignored on reads.
REQ-024 On B or R handshake: resp[1]=0 (OKAY/EXOKAY) -> wb_ack_o=1; resp[1]=1 (SLVERR/DECERR) -> wb_err_o=1; pulse lasts the one cycle in DONE; ack and err never both high.
REQ-025 R handshake loads m_axi_rdata into wb_dat_o regardless of rresp; wb_dat_o holds until the next R handshake.
REQ-026 DONE lasts one cycle, then IDLE; a request is not sampled in DONE; back-to-back strobes are accepted from IDLE.
REQ-027 Minimum latency with ready/valid returned immediately: ack/err high on the 3rd cycle after the cycle stb is first sampled in IDLE.
REQ-028 If wb_cyc_i drops after acceptance, the AXI transaction SHALL still complete; the ack/err pulse is suppressed and the FSM returns to IDLE.
REQ-029 bvalid/rvalid outside WRESP/RRESP, and awready/wready/arready with the matching valid low, SHALL be ignored.
REQ-030 Only one AXI transaction is outstanding at a time.

Reset
REQ-031 While wb_rst_i=1 at a clock edge: state=IDLE, all AXI valid/ready outputs, wb_ack_o and wb_err_o 0, wb_dat_o=0x00000000, address/data/strobe registers 0; this applies in every state, and in-flight AXI responses are discarded.

Verification
REQ-032 Write adr 0x70000010, dat 0xDEADBEEF, sel 0xF; awready=wready=1, bvalid next cycle, bresp=00 -> awaddr/wdata/wstrb match; wb_ack_o one cycle, 3 cycles after stb sampled; wb_err_o=0.
REQ-033 Read adr 0x70000020, arready held low 4 cycles, rdata 0x12345678 -> arvalid/araddr stable 5 cycles; wb_dat_o=0x12345678 in the ack cycle.
REQ-034 Write with wready in cycle 1 and awready in cycle 3 -> wvalid low from cycle 2, awvalid high through cycle 3; bready only after cycle 3.
REQ-035 Read with rresp=10, then write with bresp=11 -> each gives a one-cycle wb_err_o with wb_ack_o=0.
REQ-036 wb_rst_i pulsed in RRESP, rvalid arrives 2 cycles later -> next cycle all outputs 0; rvalid ignored; no ack.
REQ-037 wb_cyc_i dropped in WRESP -> bready held until bvalid; no ack or err; IDLE one cycle after DONE.

Source files
------------

// File: rtl/wb2axi4l_bridge_if.sv
// wb2axi4l_bridge_if: Wishbone classic slave bus and AXI4-Lite master bus bundles
// used by the bridge; signal names follow the Wishbone/AXI pin names.
interface wb_if #(parameter int ADDR_WIDTH = 32);
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic [3:0]            wb_sel_i;
    logic                  wb_we_i;
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

interface axil_if #(parameter int ADDR_WIDTH = 32);
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [31:0]           m_axi_wdata;
    logic [3:0]            m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [31:0]           m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface

// File: rtl/wb2axi4l_bridge.sv
// wb2axi4l_bridge: Wishbone classic slave to AXI4-Lite master, one transaction at a time,
// all outputs registered.
module wb2axi4l_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input logic    wb_clk_i,
    input logic    wb_rst_i,
    wb_if.slave    wb,
    axil_if.master axi
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] adr, adr_n;
    logic [31:0] wdata, wdata_n, rdat, rdat_n;
    logic [3:0] sel, sel_n;
    logic awv, awv_n, wv, wv_n, arv, arv_n;
    logic brdy, brdy_n, rrdy, rrdy_n;
    logic ack, ack_n, err, err_n, drop, drop_n;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            adr   <= '0;
            wdata <= '0;
            sel   <= '0;
            rdat  <= '0;
            awv   <= 1'b0;
            wv    <= 1'b0;
            arv   <= 1'b0;
            brdy  <= 1'b0;
            rrdy  <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            adr   <= adr_n;
            wdata <= wdata_n;
            sel   <= sel_n;
            rdat  <= rdat_n;
            awv   <= awv_n;
            wv    <= wv_n;
            arv   <= arv_n;
            brdy  <= brdy_n;
            rrdy  <= rrdy_n;
            ack   <= ack_n;
            err   <= err_n;
            drop  <= drop_n;
        end
    end
    // drop remembers that the master abandoned the cycle, so the response is swallowed
    always_comb begin
        state_n = state;
        adr_n   = adr;
        wdata_n = wdata;
        sel_n   = sel;
        rdat_n  = rdat;
        awv_n   = awv;
        wv_n    = wv;
        arv_n   = arv;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        drop_n  = drop | ~wb.wb_cyc_i;
        case (state)
            IDLE: begin
                drop_n = 1'b0;
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    adr_n   = wb.wb_adr_i;
                    wdata_n = wb.wb_dat_i;
                    sel_n   = wb.wb_sel_i;
                    awv_n   = wb.wb_we_i;
                    wv_n    = wb.wb_we_i;
                    arv_n   = ~wb.wb_we_i;
                    state_n = wb.wb_we_i ? WADDR : RADDR;
                end
            end
            WADDR: begin
                awv_n   = awv & ~axi.m_axi_awready;
                wv_n    = wv & ~axi.m_axi_wready;
                state_n = (awv_n | wv_n) ? WADDR : WRESP;
            end
            WRESP: if (axi.m_axi_bvalid) begin
                state_n = DONE;
                ack_n   = ~drop_n & ~axi.m_axi_bresp[1];
                err_n   = ~drop_n & axi.m_axi_bresp[1];
            end
            RADDR: begin
                arv_n   = ~axi.m_axi_arready;
                state_n = arv_n ? RADDR : RRESP;
            end
            RRESP: if (axi.m_axi_rvalid) begin
                state_n = DONE;
                rdat_n  = axi.m_axi_rdata;
                ack_n   = ~drop_n & ~axi.m_axi_rresp[1];
                err_n   = ~drop_n & axi.m_axi_rresp[1];
            end
            default: state_n = IDLE;
        endcase
        brdy_n = state_n == WRESP;
        rrdy_n = state_n == RRESP;
    end
    assign axi.m_axi_awaddr  = adr;
    assign axi.m_axi_awvalid = awv;
    assign axi.m_axi_wdata   = wdata;
    assign axi.m_axi_wstrb   = sel;
    assign axi.m_axi_wvalid  = wv;
    assign axi.m_axi_bready  = brdy;
    assign axi.m_axi_araddr  = adr;
    assign axi.m_axi_arvalid = arv;
    assign axi.m_axi_rready  = rrdy;
    assign wb.wb_dat_o       = rdat;
    assign wb.wb_ack_o       = ack;
    assign wb.wb_err_o       = err;
endmodule
